sa_ip_port: RTL and testbench
=============================

Name: sa_ip_port

Overview:
- Requester-side endpoint of the system agent's IP transaction interface, instantiated once per IP block (four per system).
- Takes one local memory request from the IP core and presents it to the system agent with a priority. The priority is raised while the request waits.
- Captures the transaction ID returned on accept, then waits for the matching completion and hands read data or an error back to the core.
- Allows one outstanding transaction per port.

Parameters:
- IP_ID, 0, 2-bit owner index of this port; it must match the index the system agent uses for this IP.
- AGE_CYCLES, 4, number of consecutive unaccepted request cycles between priority increments; legal range 1..255.
- TIMEOUT, 255, maximum number of cycles in WAIT before an error completion; legal range 1..65535.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- core_req_valid  in  1  core presents a request
- core_req_ready  out  1  port can take a request (high only in IDLE)
- core_req_we  in  1  1=write, 0=read
- core_req_addr  in  16  word address
- core_req_wdata  in  32  write data
- core_req_prio  in  4  base priority
- core_rsp_valid  out  1  response available
- core_rsp_ready  in  1  core takes the response
- core_rsp_rdata  out  32  read data; 0 for writes and errors
- core_rsp_err  out  1  timeout error
- ip_req_trans  out  6  [5:2]=priority, [1]=we, [0]=request
- ip_addr  out  16  request address
- ip_dat_out  out  32  write data toward the system agent
- sa_accept  in  1  system agent accepts this port's request this cycle
- sa_trans_id  in  4  transaction ID, valid with sa_accept
- sa_done  in  1  completion strobe (broadcast to all ports)
- sa_done_owner  in  2  owner index of the completing transaction
- sa_done_id  in  4  transaction ID of the completing transaction
- sa_rd_data  in  32  read data, valid with sa_done

Behaviour:
- States: IDLE, REQ, WAIT, RESP. All transitions occur on the rising edge of clk.
- Reset (checked first, overrides everything, including mid-transaction):
  - state goes to IDLE; all outputs 0 except core_req_ready=1.
  - held address, data, ID, priority and counters are cleared.
  - A completion for a transaction issued before reset is ignored, because the port is in IDLE.
- IDLE:
  - core_req_ready=1.
  - When core_req_valid=1: latch we, addr, wdata, prio; clear age_cnt; go to REQ.
  - core_req_ready is a registered state decode; there is no combinational path from core_req_valid.
- REQ:
  - Drive ip_req_trans={cur_prio, held_we, 1}, ip_addr=held_addr, ip_dat_out=held_wdata. These are held stable until accept.
  - Handshake: a transfer occurs in any cycle where the request bit and sa_accept are both 1.
  - On transfer: latch sa_trans_id; clear the timeout counter; go to WAIT. The request bit is 0 from the next cycle.
  - On a cycle without accept: age_cnt increments. When age_cnt reaches AGE_CYCLES-1, age_cnt wraps to 0 and cur_prio increments, saturating at 15 (no wrap to 0).
  - cur_prio is reset to the core's prio for each new request.
  - sa_done is ignored in REQ.
- WAIT:
  - ip_req_trans=0.
  - A completion matches only if sa_done=1, sa_done_owner==IP_ID and sa_done_id==held ID. All other completions are ignored.
  - On a match: latch sa_rd_data (for writes, latch 0 instead); set err=0; go to RESP.
  - Without a match: the timeout counter increments. When the counter reaches TIMEOUT with no match: set rdata=0, err=1; go to RESP.
  - A match in the same cycle as expiry: the match wins and err=0.
- RESP:
  - core_rsp_valid=1; rdata and err are held stable.
  - When core_rsp_ready=1: go to IDLE next cycle.
  - The next request can be taken no earlier than one cycle after the response handshake.
- Latency, from core_req_valid in IDLE:
  - ip request bit is high at cycle +1.
  - With immediate accept and done on the first WAIT cycle, core_rsp_valid is high at cycle +3.
- ID wrap: the 4-bit ID is compared exactly. A stale completion with an equal ID from another owner is rejected by the owner check.

Test Plan:
- Read, immediate accept (ID=5), done(owner=IP_ID, id=5, data=0xDEADBEEF) on the first WAIT cycle -> core_rsp_valid at cycle +3, rdata=0xDEADBEEF, err=0.
- Write prio=3, sa_accept withheld 9 cycles with AGE_CYCLES=4 -> ip_req_trans[5:2] goes 3,3,3,3,4,4,4,4,5; address and data stable throughout; accepted with ID=2 -> WAIT.
- Prio=14, withheld 20 cycles -> priority saturates at 15 and never wraps.
- In WAIT with ID=7: done(owner=other, id=7), then done(owner=IP_ID, id=6) -> both ignored; done(owner=IP_ID, id=7, data=0x1234) -> rdata=0x1234.
- TIMEOUT=10, no done -> core_rsp_valid with err=1, rdata=0. Match in the same cycle as expiry -> err=0.
- rst pulsed in WAIT, then a matching done arrives -> port stays in IDLE, no response, core_req_ready=1. core_rsp_ready held low in RESP for 5 cycles -> response held stable and core_req_ready=0.

Source files
------------

// File: rtl/sa_ip_port_if.sv
// Bundle of core-side and system-agent-side signals for one IP transaction port.
// The port drives through 'master'; the core and system agent drive through 'slave'.
interface sa_ip_port_if;
  logic        core_req_valid;
  logic        core_req_ready;
  logic        core_req_we;
  logic [15:0] core_req_addr;
  logic [31:0] core_req_wdata;
  logic [3:0]  core_req_prio;
  logic        core_rsp_valid;
  logic        core_rsp_ready;
  logic [31:0] core_rsp_rdata;
  logic        core_rsp_err;
  logic [5:0]  ip_req_trans;
  logic [15:0] ip_addr;
  logic [31:0] ip_dat_out;
  logic        sa_accept;
  logic [3:0]  sa_trans_id;
  logic        sa_done;
  logic [1:0]  sa_done_owner;
  logic [3:0]  sa_done_id;
  logic [31:0] sa_rd_data;

  modport master (
    input  core_req_valid, core_req_we, core_req_addr, core_req_wdata, core_req_prio,
    input  core_rsp_ready,
    input  sa_accept, sa_trans_id, sa_done, sa_done_owner, sa_done_id, sa_rd_data,
    output core_req_ready, core_rsp_valid, core_rsp_rdata, core_rsp_err,
    output ip_req_trans, ip_addr, ip_dat_out
  );

  modport slave (
    output core_req_valid, core_req_we, core_req_addr, core_req_wdata, core_req_prio,
    output core_rsp_ready,
    output sa_accept, sa_trans_id, sa_done, sa_done_owner, sa_done_id, sa_rd_data,
    input  core_req_ready, core_rsp_valid, core_rsp_rdata, core_rsp_err,
    input  ip_req_trans, ip_addr, ip_dat_out
  );
endinterface

// File: rtl/sa_ip_port.sv
// Requester endpoint of the system agent IP interface: one outstanding transaction,
// priority aging while unaccepted, ID-matched completion with a WAIT timeout.
module sa_ip_port #(
  parameter logic [1:0]  IP_ID      = 2'd0,
  parameter int unsigned AGE_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic          clk,
  input logic          rst,
  sa_ip_port_if.master bus
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  localparam logic [7:0]  AgeLast = 8'(AGE_CYCLES - 1);
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  prio_q, prio_d;
  logic [3:0]  id_q, id_d;
  logic [7:0]  age_q, age_d;
  logic [15:0] tmo_q, tmo_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        done_match;

  // Completions are broadcast; only our owner index plus our held ID is ours.
  assign done_match = bus.sa_done && (bus.sa_done_owner == IP_ID) && (bus.sa_done_id == id_q);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    prio_d  = prio_q;
    id_d    = id_q;
    age_d   = age_q;
    tmo_d   = tmo_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.core_req_valid) begin
          we_d    = bus.core_req_we;
          addr_d  = bus.core_req_addr;
          wdata_d = bus.core_req_wdata;
          prio_d  = bus.core_req_prio;
          age_d   = '0;
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.sa_accept) begin
          id_d    = bus.sa_trans_id;
          tmo_d   = '0;
          state_d = StWait;
        end else if (age_q == AgeLast) begin
          age_d = '0;
          if (prio_q != 4'hf) prio_d = prio_q + 4'd1;
        end else begin
          age_d = age_q + 8'd1;
        end
      end
      StWait: begin
        if (done_match) begin
          rdata_d = we_q ? 32'h0 : bus.sa_rd_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (tmo_q == TmoLast) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      StResp: begin
        if (bus.core_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      prio_q  <= '0;
      id_q    <= '0;
      age_q   <= '0;
      tmo_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      age_q   <= age_d;
      tmo_q   <= tmo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.core_req_ready = (state_q == StIdle);
  assign bus.core_rsp_valid = (state_q == StResp);
  assign bus.core_rsp_rdata = rdata_q;
  assign bus.core_rsp_err   = err_q;
  assign bus.ip_req_trans   = (state_q == StReq) ? {prio_q, we_q, 1'b1} : 6'h0;
  assign bus.ip_addr        = addr_q;
  assign bus.ip_dat_out     = wdata_q;

endmodule

// File: tb/tb_sa_ip_port.sv
// Scoreboard bench for sa_ip_port: expected responses are queued at request time
// and compared when the port presents them to the core.
module tb_sa_ip_port;

  localparam logic [1:0]  IpId    = 2'd2;
  localparam logic [1:0]  OtherId = 2'd1;
  localparam int unsigned Age     = 4;
  localparam int unsigned Tmo     = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [32:0] sb[$];

  sa_ip_port_if bus ();

  sa_ip_port #(
    .IP_ID      (IpId),
    .AGE_CYCLES (Age),
    .TIMEOUT    (Tmo)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] aged_prio(input int base, input int k);
    int p;
    p = base + k / Age;
    return (p > 15) ? 4'hf : 4'(p);
  endfunction

  task automatic issue(input logic we, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] prio, input string tag);
    check({tag, "_req_ready"}, 32'(bus.core_req_ready), 32'd1);
    bus.core_req_valid = 1'b1;
    bus.core_req_we    = we;
    bus.core_req_addr  = addr;
    bus.core_req_wdata = wdata;
    bus.core_req_prio  = prio;
    step();
    bus.core_req_valid = 1'b0;
    bus.core_req_addr  = 16'hffff;
    bus.core_req_wdata = 32'hffffffff;
    check({tag, "_trans"}, 32'(bus.ip_req_trans), 32'({prio, we, 1'b1}));
    check({tag, "_addr"}, 32'(bus.ip_addr), 32'(addr));
    check({tag, "_wdata"}, bus.ip_dat_out, wdata);
  endtask

  task automatic accept(input logic [3:0] id, input string tag);
    bus.sa_accept   = 1'b1;
    bus.sa_trans_id = id;
    step();
    bus.sa_accept   = 1'b0;
    bus.sa_trans_id = 4'hf;
    check({tag, "_req_low"}, 32'(bus.ip_req_trans), 32'd0);
  endtask

  task automatic done(input logic [1:0] owner, input logic [3:0] id, input logic [31:0] data);
    bus.sa_done       = 1'b1;
    bus.sa_done_owner = owner;
    bus.sa_done_id    = id;
    bus.sa_rd_data    = data;
    step();
    bus.sa_done       = 1'b0;
    bus.sa_rd_data    = 32'h0;
  endtask

  task automatic take_rsp(input string tag);
    int n;
    logic [32:0] e;
    n = 0;
    while (!bus.core_rsp_valid && n < 50) begin
      step();
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(bus.core_rsp_valid), 32'd1);
    check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_rdata"}, bus.core_rsp_rdata, e[31:0]);
      check({tag, "_err"}, 32'(bus.core_rsp_err), 32'(e[32]));
    end
    bus.core_rsp_ready = 1'b1;
    step();
    bus.core_rsp_ready = 1'b0;
    check({tag, "_back_idle"}, 32'(bus.core_req_ready), 32'd1);
    check({tag, "_rsp_drop"}, 32'(bus.core_rsp_valid), 32'd0);
  endtask

  initial begin
    bus.core_req_valid = 1'b0;
    bus.core_req_we    = 1'b0;
    bus.core_req_addr  = '0;
    bus.core_req_wdata = '0;
    bus.core_req_prio  = '0;
    bus.core_rsp_ready = 1'b0;
    bus.sa_accept      = 1'b0;
    bus.sa_trans_id    = '0;
    bus.sa_done        = 1'b0;
    bus.sa_done_owner  = '0;
    bus.sa_done_id     = '0;
    bus.sa_rd_data     = '0;
    step();
    step();
    rst = 1'b0;
    check("rst_req_ready", 32'(bus.core_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(bus.core_rsp_valid), 32'd0);
    check("rst_trans", 32'(bus.ip_req_trans), 32'd0);
    check("rst_addr", 32'(bus.ip_addr), 32'd0);
    check("rst_dat", bus.ip_dat_out, 32'd0);
    check("rst_rdata", bus.core_rsp_rdata, 32'd0);
    check("rst_err", 32'(bus.core_rsp_err), 32'd0);

    // Read, immediate accept, completion on first WAIT cycle: valid at +3.
    sb.push_back({1'b0, 32'hdeadbeef});
    issue(1'b0, 16'h0100, 32'h0, 4'd2, "rd1");
    accept(4'd5, "rd1");
    done(IpId, 4'd5, 32'hdeadbeef);
    check("rd1_lat3", 32'(bus.core_rsp_valid), 32'd1);
    take_rsp("rd1");

    // Write with aging: priority steps every Age unaccepted cycles.
    sb.push_back({1'b0, 32'h0});
    issue(1'b1, 16'h0abc, 32'h5555aaaa, 4'd3, "age");
    for (int k = 0; k < 9; k++) begin
      check($sformatf("age_prio%0d", k), 32'(bus.ip_req_trans[5:2]), 32'(aged_prio(3, k)));
      check($sformatf("age_addr%0d", k), 32'(bus.ip_addr), 32'h0abc);
      check($sformatf("age_dat%0d", k), bus.ip_dat_out, 32'h5555aaaa);
      step();
    end
    check("age_prio9", 32'(bus.ip_req_trans[5:2]), 32'(aged_prio(3, 9)));
    accept(4'd2, "age");
    done(IpId, 4'd2, 32'h77777777);
    take_rsp("age");

    // Saturation at 15, then a timeout with no completion.
    sb.push_back({1'b1, 32'h0});
    issue(1'b0, 16'h0002, 32'h0, 4'd14, "sat");
    for (int k = 0; k < 20; k++) begin
      check($sformatf("sat_prio%0d", k), 32'(bus.ip_req_trans[5:2]), 32'(aged_prio(14, k)));
      step();
    end
    accept(4'd3, "sat");
    for (int i = 0; i < int'(Tmo) - 1; i++) begin
      check($sformatf("tmo_wait%0d", i), 32'(bus.core_rsp_valid), 32'd0);
      step();
    end
    check("tmo_last_wait", 32'(bus.core_rsp_valid), 32'd0);
    step();
    check("tmo_expired", 32'(bus.core_rsp_valid), 32'd1);
    take_rsp("tmo");

    // Foreign owner and wrong ID are ignored; the exact match is taken.
    sb.push_back({1'b0, 32'h00001234});
    issue(1'b0, 16'h0003, 32'h0, 4'd1, "flt");
    accept(4'd7, "flt");
    done(OtherId, 4'd7, 32'hbad0bad0);
    check("flt_owner_ignored", 32'(bus.core_rsp_valid), 32'd0);
    done(IpId, 4'd6, 32'hbad1bad1);
    check("flt_id_ignored", 32'(bus.core_rsp_valid), 32'd0);
    done(IpId, 4'd7, 32'h00001234);
    take_rsp("flt");

    // Match on the expiry cycle wins over the timeout.
    sb.push_back({1'b0, 32'hcafe0001});
    issue(1'b0, 16'h0004, 32'h0, 4'd0, "edge");
    accept(4'd9, "edge");
    for (int i = 0; i < int'(Tmo) - 1; i++) step();
    check("edge_still_wait", 32'(bus.core_rsp_valid), 32'd0);
    done(IpId, 4'd9, 32'hcafe0001);
    take_rsp("edge");

    // Reset in WAIT: a late completion for the old ID must be dropped.
    issue(1'b0, 16'h0005, 32'h0, 4'd4, "rst");
    accept(4'd4, "rst");
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstw_ready", 32'(bus.core_req_ready), 32'd1);
    done(IpId, 4'd4, 32'h99999999);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rstw_no_rsp%0d", i), 32'(bus.core_rsp_valid), 32'd0);
      check($sformatf("rstw_idle%0d", i), 32'(bus.core_req_ready), 32'd1);
      step();
    end

    // Response held while the core stalls.
    sb.push_back({1'b0, 32'h0000a5a5});
    issue(1'b0, 16'h0006, 32'h0, 4'd5, "hold");
    accept(4'd1, "hold");
    done(IpId, 4'd1, 32'h0000a5a5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_valid%0d", i), 32'(bus.core_rsp_valid), 32'd1);
      check($sformatf("hold_rdata%0d", i), bus.core_rsp_rdata, 32'h0000a5a5);
      check($sformatf("hold_busy%0d", i), 32'(bus.core_req_ready), 32'd0);
      step();
    end
    take_rsp("hold");

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
